// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter between NUM_CLIENTS cache clients and one system-bus master port.
// One client is granted at a time. The grant covers a whole transaction: an address beat,
// then either DATA_BEATS write beats or RESP_BEATS read response beats. The bus is
// released after every transaction.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no grant; pick the next requester scanning upward from rr_ptr
// ADDR   | forwarding the granted client's address/tag beat to the bus
// WDATA  | forwarding write data beats; cnt counts completed beats
// RDATA  | forwarding read response beats to the client; cnt counts beats

module mem_arbiter_rr #(
    parameter int WIDTH       = 64,
    parameter int TAG_WIDTH   = 13,
    parameter int NUM_CLIENTS = 2,
    parameter int RESP_BEATS  = 8,
    parameter int DATA_BEATS  = 8
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [NUM_CLIENTS-1:0]           client_reqcyc,
    input  logic [NUM_CLIENTS*WIDTH-1:0]     client_req,
    input  logic [NUM_CLIENTS*TAG_WIDTH-1:0] client_reqtag,
    output logic [NUM_CLIENTS-1:0]           client_reqack,
    output logic [NUM_CLIENTS-1:0]           client_respcyc,
    output logic [WIDTH-1:0]                 client_resp,
    output logic [TAG_WIDTH-1:0]             client_resptag,
    input  logic [NUM_CLIENTS-1:0]           client_respack,

    output logic                             bus_reqcyc,
    output logic [WIDTH-1:0]                 bus_req,
    output logic [TAG_WIDTH-1:0]             bus_reqtag,
    input  logic                             bus_reqack,
    input  logic                             bus_respcyc,
    input  logic [WIDTH-1:0]                 bus_resp,
    input  logic [TAG_WIDTH-1:0]             bus_resptag,
    output logic                             bus_respack
);

    localparam int GW        = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int MAX_BEATS = (RESP_BEATS > DATA_BEATS) ? RESP_BEATS : DATA_BEATS;
    localparam int CW        = $clog2(MAX_BEATS) + 1;

    localparam logic [GW-1:0] LAST_CLIENT = GW'(NUM_CLIENTS - 1);
    localparam logic [CW-1:0] RESP_LAST   = CW'(RESP_BEATS - 1);
    localparam logic [CW-1:0] DATA_LAST   = CW'(DATA_BEATS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WDATA = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    logic [1:0]    state;
    logic [GW-1:0] g;
    logic [GW-1:0] rr_ptr;
    logic [CW-1:0] cnt;

    logic [WIDTH-1:0]     req_arr [NUM_CLIENTS];
    logic [TAG_WIDTH-1:0] tag_arr [NUM_CLIENTS];

    logic                 sel_reqcyc;
    logic                 sel_respack;
    logic [WIDTH-1:0]     sel_req;
    logic [TAG_WIDTH-1:0] sel_tag;
    logic                 req_hs;
    logic                 resp_hs;

    logic                 pick_valid;
    logic [GW-1:0]        pick_idx;
    logic [GW-1:0]        pick_next;

    // Split the packed per-client buses into per-client words.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_unpack
            assign req_arr[gi] = client_req[gi*WIDTH +: WIDTH];
            assign tag_arr[gi] = client_reqtag[gi*TAG_WIDTH +: TAG_WIDTH];
        end
    endgenerate

    // Select the granted client's signals and form the beat handshakes.
    assign sel_reqcyc  = client_reqcyc[g];
    assign sel_respack = client_respack[g];
    assign sel_req     = req_arr[g];
    assign sel_tag     = tag_arr[g];
    assign req_hs      = sel_reqcyc & bus_reqack;
    assign resp_hs     = bus_respcyc & sel_respack;

    // Pick the first active requester scanning upward from rr_ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!pick_valid &&
                client_reqcyc[GW'((int'(rr_ptr) + i) % NUM_CLIENTS)]) begin
                pick_valid = 1'b1;
                pick_idx   = GW'((int'(rr_ptr) + i) % NUM_CLIENTS);
            end
        end
    end

    // The client after the winner gets first priority next time.
    assign pick_next = (pick_idx == LAST_CLIENT) ? '0 : pick_idx + GW'(1);

    // Route request and response handshakes; everything idles at zero when not forwarded.
    always_comb begin
        bus_reqcyc     = 1'b0;
        bus_req        = '0;
        bus_reqtag     = '0;
        bus_respack    = 1'b0;
        client_reqack  = '0;
        client_respcyc = '0;
        client_resp    = '0;
        client_resptag = '0;
        case (state)
            ST_ADDR, ST_WDATA: begin
                bus_reqcyc       = sel_reqcyc;
                bus_req          = sel_req;
                bus_reqtag       = sel_tag;
                client_reqack[g] = bus_reqack;
            end
            ST_RDATA: begin
                client_respcyc[g] = bus_respcyc;
                client_resp       = bus_resp;
                client_resptag    = bus_resptag;
                bus_respack       = sel_respack;
            end
            default: ;
        endcase
    end

    // Transaction FSM: grant, address beat, then the write or read burst.
    // Stalls simply hold state and cnt; a grant is never revoked except by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            g      <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        g      <= pick_idx;
                        rr_ptr <= pick_next;
                        state  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (req_hs) begin
                        cnt   <= '0;
                        state <= sel_tag[TAG_WIDTH-1] ? ST_RDATA : ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (req_hs) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == DATA_LAST) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RDATA: begin
                    if (resp_hs) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == RESP_LAST) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 2-client instance with default burst lengths and a
// 4-client instance with 2-beat bursts. Expected grants and response data are queued when
// stimulus is set up and popped as the DUT produces them.

module tb_mem_arbiter_rr;

    logic         clk;
    logic         rst;

    // 2-client instance
    logic [1:0]   c_reqcyc;
    logic [127:0] c_req;
    logic [25:0]  c_reqtag;
    logic [1:0]   c_reqack;
    logic [1:0]   c_respcyc;
    logic [63:0]  c_resp;
    logic [12:0]  c_resptag;
    logic [1:0]   c_respack;
    logic         b_reqcyc;
    logic [63:0]  b_req;
    logic [12:0]  b_reqtag;
    logic         b_reqack;
    logic         b_respcyc;
    logic [63:0]  b_resp;
    logic [12:0]  b_resptag;
    logic         b_respack;

    // 4-client instance
    logic [3:0]   q_reqcyc;
    logic [255:0] q_req;
    logic [51:0]  q_reqtag;
    logic [3:0]   q_reqack;
    logic [3:0]   q_respcyc;
    logic [63:0]  q_resp;
    logic [12:0]  q_resptag;
    logic [3:0]   q_respack;
    logic         qb_reqcyc;
    logic [63:0]  qb_req;
    logic [12:0]  qb_reqtag;
    logic         qb_reqack;
    logic         qb_respcyc;
    logic [63:0]  qb_resp;
    logic [12:0]  qb_resptag;
    logic         qb_respack;

    int checks = 0;
    int errors = 0;

    int          grant_q[$];
    int          grant4_q[$];
    logic [63:0] data_q[$];
    logic [63:0] c_addr[2];
    logic [12:0] c_tag[2];
    int          pulses;

    mem_arbiter_rr #(.WIDTH(64), .TAG_WIDTH(13), .NUM_CLIENTS(2),
                     .RESP_BEATS(8), .DATA_BEATS(8)) dut2 (
        .clk(clk), .reset(rst),
        .client_reqcyc(c_reqcyc), .client_req(c_req), .client_reqtag(c_reqtag),
        .client_reqack(c_reqack), .client_respcyc(c_respcyc), .client_resp(c_resp),
        .client_resptag(c_resptag), .client_respack(c_respack),
        .bus_reqcyc(b_reqcyc), .bus_req(b_req), .bus_reqtag(b_reqtag),
        .bus_reqack(b_reqack), .bus_respcyc(b_respcyc), .bus_resp(b_resp),
        .bus_resptag(b_resptag), .bus_respack(b_respack)
    );

    mem_arbiter_rr #(.WIDTH(64), .TAG_WIDTH(13), .NUM_CLIENTS(4),
                     .RESP_BEATS(2), .DATA_BEATS(2)) dut4 (
        .clk(clk), .reset(rst),
        .client_reqcyc(q_reqcyc), .client_req(q_req), .client_reqtag(q_reqtag),
        .client_reqack(q_reqack), .client_respcyc(q_respcyc), .client_resp(q_resp),
        .client_resptag(q_resptag), .client_respack(q_respack),
        .bus_reqcyc(qb_reqcyc), .bus_req(qb_req), .bus_reqtag(qb_reqtag),
        .bus_reqack(qb_reqack), .bus_respcyc(qb_respcyc), .bus_resp(qb_resp),
        .bus_resptag(qb_resptag), .bus_respack(qb_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int c, input logic [63:0] a, input logic [12:0] t);
        c_req[c*64 +: 64]    = a;
        c_reqtag[c*13 +: 13] = t;
        c_addr[c]            = a;
        c_tag[c]             = t;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        c_reqcyc   = '0;
        q_reqcyc   = '0;
        b_reqack   = 1'b0;
        b_respcyc  = 1'b0;
        qb_reqack  = 1'b0;
        qb_respcyc = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One read transaction on the 2-client instance, entered with the DUT in IDLE.
    task automatic read_txn(input int n, input logic [63:0] base, input int stall_k,
                            input int rst_k, input bit drop);
        int          gx;
        logic [63:0] e;
        b_reqack  = 1'b1;
        b_respcyc = 1'b0;
        c_respack = 2'b11;
        #1;
        check("idle_reqack", 64'(c_reqack), 64'(0));
        check("idle_bus_reqcyc", 64'(b_reqcyc), 64'(0));
        tick();
        gx = grant_q.pop_front();
        check("grant", 64'(c_reqack), 64'(2'b01 << gx));
        check("addr_reqcyc", 64'(b_reqcyc), 64'(1));
        check("addr", b_req, c_addr[gx]);
        check("addr_tag", 64'(b_reqtag), 64'(c_tag[gx]));
        for (int k = 0; k < n; k++) data_q.push_back(base + 64'(k));
        tick();
        b_reqack = 1'b0;
        if (drop) c_reqcyc[gx] = 1'b0;
        for (int k = 0; k < n; k++) begin
            b_respcyc = 1'b1;
            b_resp    = base + 64'(k);
            b_resptag = c_tag[gx];
            c_respack = 2'b11;
            if (k == rst_k) begin
                #1;
                check("pre_rst_respcyc", 64'(c_respcyc), 64'(2'b01 << gx));
                rst = 1'b1;
                #1;
                check("rst_respcyc", 64'(c_respcyc), 64'(0));
                check("rst_resp", c_resp, 64'(0));
                check("rst_resptag", 64'(c_resptag), 64'(0));
                check("rst_respack", 64'(b_respack), 64'(0));
                check("rst_bus_reqcyc", 64'(b_reqcyc), 64'(0));
                check("rst_reqack", 64'(c_reqack), 64'(0));
                data_q.delete();
                tick();
                rst       = 1'b0;
                b_respcyc = 1'b0;
                return;
            end
            if (k == stall_k) begin
                repeat (2) begin
                    c_respack[gx] = 1'b0;
                    #1;
                    check("stall_respack", 64'(b_respack), 64'(0));
                    check("stall_respcyc", 64'(c_respcyc), 64'(2'b01 << gx));
                    tick();
                end
                c_respack = 2'b11;
            end
            #1;
            check("respcyc", 64'(c_respcyc), 64'(2'b01 << gx));
            e = data_q.pop_front();
            check("resp_data", c_resp, e);
            check("resp_tag", 64'(c_resptag), 64'(c_tag[gx]));
            check("respack", 64'(b_respack), 64'(1));
            tick();
        end
        #1;
        check("idle_after_respcyc", 64'(c_respcyc), 64'(0));
        b_respcyc = 1'b0;
    endtask

    // One read transaction on the 4-client instance, entered with the DUT in IDLE.
    task automatic read4();
        int gx;
        qb_reqack  = 1'b1;
        qb_respcyc = 1'b0;
        q_respack  = 4'hF;
        #1;
        check("q_idle_reqack", 64'(q_reqack), 64'(0));
        tick();
        gx = grant4_q.pop_front();
        check("q_grant", 64'(q_reqack), 64'(4'b0001 << gx));
        check("q_addr", qb_req, 64'h1000 * 64'(gx + 1));
        tick();
        qb_reqack = 1'b0;
        repeat (2) begin
            qb_respcyc = 1'b1;
            qb_resp    = 64'hAB;
            #1;
            check("q_respcyc", 64'(q_respcyc), 64'(4'b0001 << gx));
            tick();
        end
        qb_respcyc = 1'b0;
    endtask

    initial begin
        // Reset with busy-looking inputs: every output must still be zero.
        rst        = 1'b0;
        c_reqcyc   = 2'b11;
        c_req      = '0;
        c_reqtag   = '0;
        c_respack  = 2'b11;
        b_reqack   = 1'b1;
        b_respcyc  = 1'b1;
        b_resp     = 64'hFFFF;
        b_resptag  = 13'h1FFF;
        q_reqcyc   = 4'hF;
        q_respack  = 4'hF;
        qb_reqack  = 1'b1;
        qb_respcyc = 1'b1;
        qb_resp    = 64'h55;
        qb_resptag = 13'h1000;
        for (int i = 0; i < 4; i++) begin
            q_req[i*64 +: 64]    = 64'h1000 * 64'(i + 1);
            q_reqtag[i*13 +: 13] = 13'h1000;
        end
        set_req(0, 64'h40, 13'h1000);
        set_req(1, 64'h80, 13'h1001);
        #1;
        rst = 1'b1;
        #1;
        check("rst_bus_reqcyc", 64'(b_reqcyc), 64'(0));
        check("rst_bus_req", b_req, 64'(0));
        check("rst_bus_reqtag", 64'(b_reqtag), 64'(0));
        check("rst_bus_respack", 64'(b_respack), 64'(0));
        check("rst_client_reqack", 64'(c_reqack), 64'(0));
        check("rst_client_respcyc", 64'(c_respcyc), 64'(0));
        check("rst_client_resp", c_resp, 64'(0));
        check("rst_client_resptag", 64'(c_resptag), 64'(0));
        check("rst_q_bus_reqcyc", 64'(qb_reqcyc), 64'(0));
        check("rst_q_reqack", 64'(q_reqack), 64'(0));
        do_reset();

        // Client 0 read, address 0x40, response data 0..7.
        set_req(0, 64'h40, 13'h1000);
        c_reqcyc = 2'b01;
        grant_q.push_back(0);
        read_txn(8, 64'h0, -1, -1, 1'b1);

        // Both clients request from reset and keep requesting: grants 0,1,0,1.
        do_reset();
        set_req(0, 64'h40, 13'h1000);
        set_req(1, 64'h80, 13'h1001);
        c_reqcyc = 2'b11;
        grant_q.push_back(0);
        grant_q.push_back(1);
        grant_q.push_back(0);
        grant_q.push_back(1);
        for (int t = 0; t < 4; t++) read_txn(8, 64'h100 * 64'(t + 1), -1, -1, 1'b0);
        c_reqcyc = 2'b00;

        // Client 1 write with a 3-cycle bus stall before data beat 4.
        do_reset();
        set_req(1, 64'h80, 13'h0040);
        c_reqcyc  = 2'b10;
        grant_q.push_back(1);
        b_reqack  = 1'b1;
        b_respcyc = 1'b1;
        c_respack = 2'b11;
        pulses    = 0;
        #1;
        check("w_idle_reqack", 64'(c_reqack), 64'(0));
        tick();
        check("w_grant", 64'(c_reqack), 64'(2'b01 << grant_q.pop_front()));
        check("w_addr", b_req, 64'h80);
        if (c_reqack[1]) pulses++;
        tick();
        for (int d = 1; d <= 8; d++) begin
            set_req(1, 64'hD0 + 64'(d), 13'h0040);
            if (d == 4) begin
                b_reqack = 1'b0;
                repeat (3) begin
                    #1;
                    check("w_stall_hold", b_req, 64'hD4);
                    check("w_stall_reqack", 64'(c_reqack), 64'(0));
                    tick();
                end
                b_reqack = 1'b1;
            end
            #1;
            check("w_data", b_req, 64'hD0 + 64'(d));
            check("w_no_respcyc", 64'(c_respcyc), 64'(0));
            check("w_no_respack", 64'(b_respack), 64'(0));
            if (c_reqack[1]) pulses++;
            tick();
        end
        #1;
        check("w_idle_after", 64'(c_reqack), 64'(0));
        check("w_pulses", 64'(pulses), 64'(9));
        c_reqcyc  = 2'b00;
        b_respcyc = 1'b0;
        tick();

        // Client 0 read with client_respack low for 2 cycles at beat 2.
        do_reset();
        set_req(0, 64'h44, 13'h1002);
        c_reqcyc = 2'b01;
        grant_q.push_back(0);
        read_txn(8, 64'h200, 2, -1, 1'b1);

        // Reset during read beat 3 with client 1 pending; client 1 is granted afterwards.
        do_reset();
        set_req(0, 64'h48, 13'h1003);
        set_req(1, 64'h88, 13'h1004);
        c_reqcyc = 2'b11;
        grant_q.push_back(0);
        read_txn(8, 64'h300, -1, 3, 1'b1);
        b_reqack = 1'b0;
        #1;
        check("post_rst_idle", 64'(b_reqcyc), 64'(0));
        tick();
        check("post_rst_reqcyc", 64'(b_reqcyc), 64'(1));
        check("post_rst_addr", b_req, 64'h88);
        c_reqcyc = 2'b00;

        // Four clients requesting continuously: 0,1,2,3,0; then without client 2: 0,1,3,0.
        do_reset();
        q_reqcyc = 4'hF;
        grant4_q.push_back(0);
        grant4_q.push_back(1);
        grant4_q.push_back(2);
        grant4_q.push_back(3);
        grant4_q.push_back(0);
        repeat (5) read4();
        do_reset();
        q_reqcyc = 4'b1011;
        grant4_q.push_back(0);
        grant4_q.push_back(1);
        grant4_q.push_back(3);
        grant4_q.push_back(0);
        repeat (4) read4();
        q_reqcyc = 4'h0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
